// File: rtl/enc_pkg.sv
// Shared types and helpers for the 8-to-3 encoder.
//   ENC_IN_W / ENC_OUT_W : fixed request and index widths
//   enc_in_t / enc_idx_t : request vector and encoded index types
//   enc_rsp_t            : {idx, any, multi} bundle produced by the core
//   onehot_check()       : true when exactly one bit is set
package enc_pkg;

  localparam int ENC_IN_W  = 8;
  localparam int ENC_OUT_W = 3;

  typedef logic [ENC_IN_W-1:0]  enc_in_t;
  typedef logic [ENC_OUT_W-1:0] enc_idx_t;

  typedef struct packed {
    enc_idx_t idx;
    logic     any;
    logic     multi;
  } enc_rsp_t;

  // Clearing the lowest set bit leaves zero only for one-hot or all-zero
  // vectors, so the extra non-zero test isolates the one-hot case.
  function automatic logic onehot_check(input enc_in_t v);
    return (v != '0) && ((v & (v - enc_in_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/eight_to_three_prio_core.sv
// Combinational priority encoder core.
//   a     : request vector, bit i means "index i"
//   idx   : index of the most-significant set bit (0 when a is zero)
//   any   : at least one bit of a set
//   multi : more than one bit of a set
module eight_to_three_prio_core
  import enc_pkg::*;
(
  input  enc_in_t  a,
  output enc_idx_t idx,
  output logic     any,
  output logic     multi
);

  // Ascending scan: later (higher) hits overwrite earlier ones, so the
  // highest set bit wins.
  always_comb begin
    idx = '0;
    for (int i = 0; i < ENC_IN_W; i++) begin
      if (a[i]) idx = enc_idx_t'(i);
    end
  end

  assign any   = |a;
  assign multi = any & ~onehot_check(a);

endmodule

// File: rtl/eight_to_three_encoder.sv
// Registered 8-to-3 encoder with priority resolution.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset, clears all outputs
//   a     : request vector, sampled every rising edge
//   y     : encoded index of the highest set bit, one cycle after sampling
//   valid : sampled a was non-zero (qualifies y)
//   multi : sampled a had more than one bit set
module eight_to_three_encoder
  import enc_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  enc_in_t  a,
  output enc_idx_t y,
  output logic     valid,
  output logic     multi
);

  enc_rsp_t rsp_d;
  enc_rsp_t rsp_q;

  eight_to_three_prio_core u_core (
    .a     (a),
    .idx   (rsp_d.idx),
    .any   (rsp_d.any),
    .multi (rsp_d.multi)
  );

  // Only state in the block; each cycle is independent of history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rsp_q <= '0;
    else     rsp_q <= rsp_d;
  end

  assign y     = rsp_q.idx;
  assign valid = rsp_q.any;
  assign multi = rsp_q.multi;

endmodule

// File: tb/tb_eight_to_three_encoder.sv
module tb_eight_to_three_encoder;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [2:0] y;
  logic       valid;
  logic       multi;

  int n_chk;
  int n_fail;

  eight_to_three_encoder dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .y     (y),
    .valid (valid),
    .multi (multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [2:0] y;
    logic       v;
    logic       m;
  } vec_t;

  // Reference: index of the top set bit via repeated halving, multi via
  // population count.
  task automatic model(input logic [7:0] v, output logic [2:0] ey,
                       output logic ev, output logic em);
    int val;
    int lg;
    val = int'(v);
    lg  = 0;
    while (val > 1) begin
      val = val / 2;
      lg++;
    end
    ey = 3'(lg);
    ev = (v != 8'd0);
    em = ($countones(v) > 1);
  endtask

  task automatic check(input string name, input logic [2:0] ey,
                       input logic ev, input logic em);
    n_chk++;
    if (y !== ey || valid !== ev || multi !== em) begin
      n_fail++;
      $display("FAIL %s: got y=%0d valid=%b multi=%b, want y=%0d valid=%b multi=%b",
               name, y, valid, multi, ey, ev, em);
    end
  endtask

  // Drive a away from the active edge, sample just after the next one.
  task automatic step(input logic [7:0] v);
    @(negedge clk);
    a = v;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    logic [2:0] ey;
    logic       ev, em;
    logic [7:0] r;
    n_chk  = 0;
    n_fail = 0;

    // Reset held with all-ones input: outputs stay cleared across edges.
    rst = 1'b1;
    a   = 8'hFF;
    #1;
    check("reset_t0", 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", 3'd0, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_release_ff", 3'd7, 1'b1, 1'b1);

    // Directed table: one-hot sweep, zero after 0x10, multi-hot priority.
    for (int i = 0; i < 8; i++) begin
      r = 8'd1 << i;
      tbl.push_back('{a: r, y: 3'(i), v: 1'b1, m: 1'b0});
    end
    tbl.push_back('{a: 8'h10, y: 3'd4, v: 1'b1, m: 1'b0});
    tbl.push_back('{a: 8'h00, y: 3'd0, v: 1'b0, m: 1'b0});
    tbl.push_back('{a: 8'h81, y: 3'd7, v: 1'b1, m: 1'b1});
    tbl.push_back('{a: 8'h06, y: 3'd2, v: 1'b1, m: 1'b1});
    tbl.push_back('{a: 8'hFF, y: 3'd7, v: 1'b1, m: 1'b1});
    foreach (tbl[i]) begin
      step(tbl[i].a);
      check($sformatf("table_%0d_a%02h", i, tbl[i].a), tbl[i].y, tbl[i].v, tbl[i].m);
    end

    // Output must not follow a before the edge.
    @(negedge clk);
    a = 8'h01;
    #2;
    check("no_comb_path", 3'd7, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check("after_edge_01", 3'd0, 1'b1, 1'b0);

    // Random vectors against the reference model.
    for (int i = 0; i < 300; i++) begin
      r = 8'($urandom_range(0, 255));
      if (i % 4 == 0) r = r & 8'($urandom_range(0, 255)); // bias toward sparse
      step(r);
      model(r, ey, ev, em);
      check($sformatf("rand_a%02h", r), ey, ev, em);
    end

    // Async reset mid-stream.
    step(8'h40);
    check("pre_async_rst", 3'd6, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_clear", 3'd0, 1'b0, 1'b0);
    a = 8'h08;
    @(posedge clk);
    #1;
    check("async_rst_hold", 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_async_rst", 3'd3, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
